reg_dump_unit: RTL and testbench

Debug read-out engine for the CPU's 8×8 register file. On a `start` pulse it walks register addresses 0..NUM_REGS-1 through a register-file read port and streams each byte out on a valid/ready byte interface toward the debug/UART path. It is the reading counterpart to the register-file write path and uses one spare combinational read port, with no write access.

---
 rtl/reg_dump_unit.sv | 132 +++++++++++++
 tb/tb_reg_dump_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks addresses 0..NUM_REGS-1 and streams each byte on a valid/ready port.
// Optional trailing XOR checksum beat is enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump_unit #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] idx;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // rf_addr is advanced on the edge that enters LOAD, so the combinational
  // read data is already settled for the whole LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      rf_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state   <= LOAD;
              idx     <= '0;
              rf_addr <= '0;
              busy    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
              csum    <= '0;
`endif
            end
          end
          LOAD: begin
            out_data  <= rf_data;
            out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            out_last  <= 1'b0;
`else
            out_last  <= (idx == LAST_IDX);
`endif
            state     <= SEND;
          end
          SEND: begin
            if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
              csum <= csum ^ out_data;
`endif
              if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                // Checksum beat follows immediately; out_valid stays up.
                out_data <= csum ^ out_data;
                out_last <= 1'b1;
                state    <= CSUM;
`else
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
`endif
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                idx       <= idx + ADDR_W'(1);
                rf_addr   <= idx + ADDR_W'(1);
                state     <= LOAD;
              end
            end
          end
`ifdef REG_DUMP_CHECKSUM_EN
          CSUM: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
`endif
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: basic dump, backpressure, live writes, abort, reset.
// Expectations adapt to REG_DUMP_CHECKSUM_EN when the bench is built with it.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, abort, out_ready;
  logic [2:0] rf_addr;
  logic [7:0] rf_data, out_data;
  logic       out_valid, out_last, busy, done;
  logic [7:0] rf [8];
  int         errors = 0;
  int         checks = 0;

  assign rf_data = rf[rf_addr];

  always #5 clk = ~clk;

  reg_dump_unit #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rf();
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rf[1] = 8'h01;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    clear_rf();
    step(); step();
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {out_valid, out_last, busy, done});
    end
    checks++;
    if ({rf_addr, out_data} !== 11'h0) begin
      errors++; $display("[TB] FAIL reset_addr_data: got addr=%0h data=%0h expected 0/0", rf_addr, out_data);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_release_idle: got %b expected 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [8];
    logic       exp_v;
    exp_b = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_rf();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      exp_v = ((cyc % 2 == 0) && cyc >= 2 && cyc <= 16) || (CS == 1 && cyc == 17);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("[TB] FAIL basic_valid c%0d: got %b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v && cyc <= 16) begin
        checks++;
        if (out_data !== exp_b[(cyc - 2) / 2]) begin
          errors++; $display("[TB] FAIL basic_data c%0d: got %h expected %h", cyc, out_data, exp_b[(cyc - 2) / 2]);
        end
        checks++;
        if (out_last !== (CS == 0 && cyc == 16)) begin
          errors++; $display("[TB] FAIL basic_last c%0d: got %b expected %b", cyc, out_last, (CS == 0 && cyc == 16));
        end
      end
      if (exp_v && cyc == 17) begin
        checks++;
        if ({out_data, out_last} !== {8'h01, 1'b1}) begin
          errors++; $display("[TB] FAIL basic_csum_beat: got %h/%b expected 01/1", out_data, out_last);
        end
      end
      if (cyc % 2 == 1 && cyc <= 15) begin
        checks++;
        if (rf_addr !== 3'((cyc - 1) / 2)) begin
          errors++; $display("[TB] FAIL basic_rf_addr c%0d: got %0d expected %0d", cyc, rf_addr, (cyc - 1) / 2);
        end
      end
      checks++;
      if (done !== (cyc == 17 + CS)) begin
        errors++; $display("[TB] FAIL basic_done c%0d: got %b expected %b", cyc, done, (cyc == 17 + CS));
      end
      checks++;
      if (busy !== (cyc <= 17 + CS)) begin
        errors++; $display("[TB] FAIL basic_busy c%0d: got %b expected %b", cyc, busy, (cyc <= 17 + CS));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    logic [7:0] exp_d;
    logic       exp_v;
    int         bi;
    for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      out_ready = !(cyc >= 8 && cyc <= 12);
      exp_v = 1'b0; bi = 0;
      if (cyc >= 2 && cyc <= 6 && cyc % 2 == 0) begin exp_v = 1'b1; bi = (cyc - 2) / 2; end
      else if (cyc >= 8 && cyc <= 13) begin exp_v = 1'b1; bi = 3; end
      else if (cyc >= 15 && cyc <= 21 && cyc % 2 == 1) begin exp_v = 1'b1; bi = (cyc - 15) / 2 + 4; end
      else if (CS == 1 && cyc == 22) begin exp_v = 1'b1; bi = 8; end
      exp_d = (bi < 8) ? 8'h10 + 8'(bi) : 8'h00;
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("[TB] FAIL bp_valid c%0d: got %b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== exp_d) begin
          errors++; $display("[TB] FAIL bp_data c%0d: got %h expected %h", cyc, out_data, exp_d);
        end
        checks++;
        if (out_last !== (bi == 7 + CS)) begin
          errors++; $display("[TB] FAIL bp_last c%0d: got %b expected %b", cyc, out_last, (bi == 7 + CS));
        end
      end
      checks++;
      if (done !== (cyc == 22 + CS)) begin
        errors++; $display("[TB] FAIL bp_done c%0d: got %b expected %b", cyc, done, (cyc == 22 + CS));
      end
      if (out_valid && out_ready) got.push_back(out_data);
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (got.size() !== 8 + CS) begin
      errors++; $display("[TB] FAIL bp_beat_count: got %0d expected %0d", got.size(), 8 + CS);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== 8'h10 + 8'(i)) begin
          errors++; $display("[TB] FAIL bp_stream[%0d]: got %h expected %h", i, got[i], 8'h10 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_live_write();
    clear_rf();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 18 + CS; cyc++) begin
      if (cyc == 3) begin rf[5] = 8'hAA; rf[0] = 8'h55; end
      if (cyc == 2) begin
        checks++;
        if (out_data !== 8'h00) begin
          errors++; $display("[TB] FAIL live_beat0: got %h expected 00", out_data);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (out_data !== 8'h01) begin
          errors++; $display("[TB] FAIL live_beat1: got %h expected 01", out_data);
        end
      end
      if (cyc == 12) begin
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'hAA}) begin
          errors++; $display("[TB] FAIL live_beat5: got v=%b %h expected v=1 AA", out_valid, out_data);
        end
      end
      if (cyc == 17 + CS) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("[TB] FAIL live_done: got %b expected 1", done);
        end
      end
      step();
    end
  endtask

  task automatic test_abort();
    clear_rf();
    rf[0] = 8'h5A; rf[4] = 8'h44;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h44}) begin
      errors++; $display("[TB] FAIL abort_pre_beat4: got v=%b %h expected v=1 44", out_valid, out_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++; $display("[TB] FAIL abort_drop: got %b expected 000", {out_valid, busy, done});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
        errors++; $display("[TB] FAIL abort_stay_idle %0d: got %b expected 000", i, {out_valid, busy, done});
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, rf_addr} !== {1'b1, 3'd0}) begin
      errors++; $display("[TB] FAIL restart_load: got busy=%b addr=%0d expected 1/0", busy, rf_addr);
    end
    step();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
      errors++; $display("[TB] FAIL restart_beat0: got v=%b %h expected v=1 5A", out_valid, out_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL start_abort_idle: got %b expected 00", {busy, out_valid});
    end
    step();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL start_abort_idle2: got %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_start_busy_reset();
    clear_rf();
    rf[3] = 8'h33; rf[4] = 8'h44;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, out_valid, rf_addr} !== {1'b1, 1'b0, 3'd3}) begin
      errors++; $display("[TB] FAIL busy_start_c7: got busy=%b v=%b addr=%0d expected 1/0/3", busy, out_valid, rf_addr);
    end
    step();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h33}) begin
      errors++; $display("[TB] FAIL busy_start_c8: got v=%b %h expected v=1 33", out_valid, out_data);
    end
    step();
    checks++;
    if ({busy, rf_addr, out_data} !== {1'b1, 3'd4, 8'h33}) begin
      errors++; $display("[TB] FAIL pre_reset_c9: got busy=%b addr=%0d data=%h expected 1/4/33", busy, rf_addr, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, rf_addr, out_data} !== 15'h0) begin
      errors++; $display("[TB] FAIL async_reset: got v=%b l=%b b=%b d=%b addr=%0d data=%h expected all 0",
                         out_valid, out_last, busy, done, rf_addr, out_data);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({busy, out_valid, done} !== 3'b000) begin
      errors++; $display("[TB] FAIL post_reset_idle: got %b expected 000", {busy, out_valid, done});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h00}) begin
      errors++; $display("[TB] FAIL post_reset_beat0: got v=%b %h expected v=1 00", out_valid, out_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

`ifdef REG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < 8; i++) rf[i] = 8'(i + 1);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      if (cyc >= 2 && cyc <= 16 && cyc % 2 == 0) begin
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'((cyc - 2) / 2 + 1)}) begin
          errors++; $display("[TB] FAIL csum_beat c%0d: got v=%b l=%b %h expected v=1 l=0 %h",
                             cyc, out_valid, out_last, out_data, 8'((cyc - 2) / 2 + 1));
        end
      end
      if (cyc == 17) begin
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h08}) begin
          errors++; $display("[TB] FAIL csum_final: got v=%b l=%b %h expected v=1 l=1 08", out_valid, out_last, out_data);
        end
      end
      checks++;
      if (done !== (cyc == 18)) begin
        errors++; $display("[TB] FAIL csum_done c%0d: got %b expected %b", cyc, done, (cyc == 18));
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_live_write();
    test_abort();
    test_start_busy_reset();
`ifdef REG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
